// File: rtl/map_update_if.sv
// map_update_if: requester/vsync inputs and ack/status/display-map outputs of map_update_ctrl.
interface map_update_if;
    logic         vsync;
    logic         req_l;
    logic [7:0]   pos_l;
    logic [5:0]   card_l;
    logic         req_r;
    logic [7:0]   pos_r;
    logic [5:0]   card_r;
    logic         clear_req;
    logic         ack_l;
    logic         ack_r;
    logic         err;
    logic         busy;
    logic         dirty;
    logic         commit_pulse;
    logic [863:0] map_disp;
    modport master (
        output vsync, req_l, pos_l, card_l, req_r, pos_r, card_r, clear_req,
        input  ack_l, ack_r, err, busy, dirty, commit_pulse, map_disp
    );
    modport slave (
        input  vsync, req_l, pos_l, card_l, req_r, pos_r, card_r, clear_req,
        output ack_l, ack_r, err, busy, dirty, commit_pulse, map_disp
    );
endinterface

// File: rtl/map_update_ctrl.sv
// map_update_ctrl: arbitrates card-map writes into a shadow map, sequences clears,
// and commits shadow to the display map at vertical-blank start.
module map_update_ctrl #(
    parameter logic [5:0] EMPTY_CODE = 6'd63,
    parameter int         NUM_POS    = 144,
    parameter logic [5:0] MAX_CARD   = 6'd53
) (
    input logic       clk,
    input logic       rst,
    map_update_if.slave bus
);
    localparam logic [7:0] LAST_POS = 8'(NUM_POS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state;
    logic [5:0] shadow [NUM_POS];
    logic [7:0] cnt;
    logic       last_r, vs_s1, vs_s2, vs_q;
    logic       idle, vblank_start, el_l, el_r, gnt_l, gnt_r, bad, wr, commit, clear_done;
    logic [7:0] g_pos;
    logic [5:0] g_card;

    always_comb begin
        idle         = state == IDLE;
        vblank_start = vs_q & ~vs_s2;
        // a side being acked this cycle still holds req, so it must not win again
        el_l         = bus.req_l & ~bus.ack_l;
        el_r         = bus.req_r & ~bus.ack_r;
        gnt_l        = idle & el_l & (~el_r | last_r);
        gnt_r        = idle & el_r & ~gnt_l;
        g_pos        = gnt_l ? bus.pos_l : bus.pos_r;
        g_card       = gnt_l ? bus.card_l : bus.card_r;
        bad          = (g_pos > LAST_POS) | ((g_card > MAX_CARD) & (g_card != EMPTY_CODE));
        wr           = (gnt_l | gnt_r) & ~bad;
        commit       = vblank_start & bus.dirty & idle;
        clear_done   = (state == CLEAR) & (cnt == LAST_POS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_POS; i++) shadow[i] <= EMPTY_CODE;
            bus.map_disp     <= {NUM_POS{EMPTY_CODE}};
            state            <= IDLE;
            cnt              <= '0;
            last_r           <= 1'b1;
            {vs_q, vs_s2, vs_s1} <= 3'b111;
            bus.ack_l        <= 1'b0;
            bus.ack_r        <= 1'b0;
            bus.err          <= 1'b0;
            bus.busy         <= 1'b0;
            bus.dirty        <= 1'b0;
            bus.commit_pulse <= 1'b0;
        end else begin
            {vs_q, vs_s2, vs_s1} <= {vs_s2, vs_s1, bus.vsync};
            bus.ack_l        <= gnt_l;
            bus.ack_r        <= gnt_r;
            bus.err          <= (gnt_l | gnt_r) & bad;
            bus.commit_pulse <= commit;
            if (gnt_l | gnt_r) last_r <= gnt_r;
            if (wr) shadow[g_pos] <= g_card;
            // nonblocking read of shadow gives the pre-write value on a same-cycle write
            if (commit) for (int i = 0; i < NUM_POS; i++) bus.map_disp[6*i +: 6] <= shadow[i];
            if (wr | clear_done) bus.dirty <= 1'b1;
            else if (commit) bus.dirty <= 1'b0;
            if (state == CLEAR) begin
                shadow[cnt] <= EMPTY_CODE;
                cnt         <= clear_done ? 8'd0 : cnt + 8'd1;
                if (clear_done) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            end else if (bus.clear_req) begin
                state    <= CLEAR;
                bus.busy <= 1'b1;
            end
        end
    end
endmodule
